// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the MM.SS multiplexed 7-segment display driver.
package stopwatch_display_pkg;

    localparam int unsigned VAL_W = 6;
    localparam int unsigned AN_W  = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    // Digit index, rightmost first: sec ones, sec tens, min ones, min tens
    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } digit_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} patterns, entry [0] is digit 0
    localparam logic [9:0][SEG_W-1:0] SEG_LUT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic digit_e next_digit(digit_e d);
        digit_e n;
        n = D0;
        case (d)
            D0:      n = D1;
            D1:      n = D2;
            D2:      n = D3;
            default: n = D0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Value inputs and display outputs of the stopwatch display stage.
interface stopwatch_display_if;
    import stopwatch_display_pkg::*;

    logic [VAL_W-1:0] minutes;
    logic [VAL_W-1:0] seconds;
    logic             adj_en;
    logic             sel;
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;
    logic             dp;

    modport master (output minutes, seconds, adj_en, sel, input an, seg, dp);
    modport slave  (input minutes, seconds, adj_en, sel, output an, seg, dp);

endinterface

// File: rtl/stopwatch_display_decoder.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 are blank.
module seven_seg_decoder
    import stopwatch_display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (bcd <= 4'd9) seg_c = SEG_LUT[bcd];
    end

endmodule

// File: rtl/stopwatch_display.sv
// 4-digit MM.SS multiplexed display: scan, snapshot, BCD split, adjust blink.
// Optional `LEADING_ZERO_BLANK_EN blanks the minutes-tens digit when it is zero.
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_display_if.slave   bus
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0]    refresh_cnt;
    logic             refresh_tick_c;
    logic             show_tick;
    logic [BW-1:0]    blink_cnt;
    logic             blink_hidden;
    digit_e           digit;
    logic             scan_active;
    logic [VAL_W-1:0] min_snap;
    logic [VAL_W-1:0] sec_snap;

    logic             field_is_sec_c;
    logic [VAL_W-1:0] field_val_c;
    logic [BCD_W-1:0] bcd_c;
    logic [SEG_W-1:0] dec_seg_c;
    logic [SEG_W-1:0] seg_next_c;
    logic [AN_W-1:0]  an_next_c;
    logic             dp_next_c;

    logic [AN_W-1:0]  disp_an;
    logic [SEG_W-1:0] disp_seg;
    logic             disp_dp;

    assign refresh_tick_c = (refresh_cnt == RW'(REFRESH_DIV - 1));

    // Digit-rate clock enable; show_tick delays it so outputs follow the new index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            show_tick   <= 1'b0;
        end else begin
            refresh_cnt <= refresh_tick_c ? '0 : refresh_cnt + RW'(1);
            show_tick   <= refresh_tick_c;
        end
    end

    // Blink phase only advances in adjust mode; leaving it snaps back to visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (!bus.adj_en) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
        end else begin
            blink_cnt    <= blink_cnt + BW'(1);
        end
    end

    // Scan FSM; the first tick after reset enters D0, and every entry to D0 latches a new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit       <= D0;
            scan_active <= 1'b0;
            min_snap    <= '0;
            sec_snap    <= '0;
        end else if (refresh_tick_c) begin
            if (!scan_active || digit == D3) begin
                digit    <= D0;
                min_snap <= bus.minutes;
                sec_snap <= bus.seconds;
            end else begin
                digit    <= next_digit(digit);
            end
            scan_active <= 1'b1;
        end
    end

    always_comb begin
        field_is_sec_c = (digit == D0) || (digit == D1);
        field_val_c    = field_is_sec_c ? sec_snap : min_snap;
        if (digit == D0 || digit == D2) bcd_c = 4'(field_val_c % VAL_W'(10));
        else                            bcd_c = 4'(field_val_c / VAL_W'(10));
    end

    seven_seg_decoder u_decoder (
        .bcd   (bcd_c),
        .seg_c (dec_seg_c)
    );

    always_comb begin
        seg_next_c = dec_seg_c;
        if (field_val_c > VAL_W'(59)) seg_next_c = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
        else if (digit == D3 && bcd_c == 4'd0) seg_next_c = SEG_BLANK;
`endif
        if (bus.adj_en && blink_hidden && (bus.sel == field_is_sec_c)) seg_next_c = SEG_BLANK;

        an_next_c = 4'b1111;
        case (digit)
            D0:      an_next_c = 4'b1110;
            D1:      an_next_c = 4'b1101;
            D2:      an_next_c = 4'b1011;
            default: an_next_c = 4'b0111;
        endcase
        dp_next_c = (digit != D2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_an  <= 4'b1111;
            disp_seg <= SEG_BLANK;
            disp_dp  <= 1'b1;
        end else if (show_tick) begin
            disp_an  <= an_next_c;
            disp_seg <= seg_next_c;
            disp_dp  <= dp_next_c;
        end
    end

    assign bus.an  = disp_an;
    assign bus.seg = disp_seg;
    assign bus.dp  = disp_dp;

endmodule
